descrypt_round_ctrl: RTL and testbench

- Sequencer for one descrypt hashing core: accepts a key/salt job, drives the 16-round DES datapath for ITERATIONS passes, then captures the result through the final permutation FP (= IP^-1) into an output register.
- Sits between the job distributor (key generator) and the result comparator.
- Owns all round/iteration counters, datapath strobes and both valid/ready handshakes.

---
 rtl/descrypt_round_ctrl.sv | 177 +++++++++++++++++
 tb/tb_descrypt_round_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/descrypt_round_ctrl.sv
// descrypt_round_ctrl: job sequencer for one descrypt DES core (load, 16 rounds x ITERATIONS, FP capture).
// Optional abort input is enabled by defining DESCRYPT_CTRL_ABORT_EN.
module descrypt_round_ctrl #(
    parameter int ITERATIONS = 25,
    parameter int ROUNDS     = 16
) (
    input  logic        CLK,
    input  logic        rst_n,
`ifdef DESCRYPT_CTRL_ABORT_EN
    input  logic        abort,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [55:0] in_key,
    input  logic [11:0] in_salt,
    output logic        dp_load,
    output logic [55:0] dp_key,
    output logic [11:0] dp_salt,
    output logic        dp_round_en,
    output logic        dp_shift2,
    output logic        dp_iter_end,
    input  logic [63:0] dp_lr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_hash,
    output logic        busy
);
    localparam int IW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam logic [IW-1:0] ITER_LAST  = IW'(ITERATIONS - 1);
    localparam logic [3:0]    ROUND_LAST = 4'(ROUNDS - 1);

    // Source bit index (LSB = 0) for each FP output bit, MSB first.
    localparam logic [5:0] FP_SRC [64] = '{
        6'd24, 6'd56, 6'd16, 6'd48, 6'd8,  6'd40, 6'd0, 6'd32,
        6'd25, 6'd57, 6'd17, 6'd49, 6'd9,  6'd41, 6'd1, 6'd33,
        6'd26, 6'd58, 6'd18, 6'd50, 6'd10, 6'd42, 6'd2, 6'd34,
        6'd27, 6'd59, 6'd19, 6'd51, 6'd11, 6'd43, 6'd3, 6'd35,
        6'd28, 6'd60, 6'd20, 6'd52, 6'd12, 6'd44, 6'd4, 6'd36,
        6'd29, 6'd61, 6'd21, 6'd53, 6'd13, 6'd45, 6'd5, 6'd37,
        6'd30, 6'd62, 6'd22, 6'd54, 6'd14, 6'd46, 6'd6, 6'd38,
        6'd31, 6'd63, 6'd23, 6'd55, 6'd15, 6'd47, 6'd7, 6'd39
    };

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_ITER_END, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    round_q, round_d;
    logic [IW-1:0] iter_q, iter_d;
    logic [55:0]   key_q, key_d;
    logic [11:0]   salt_q, salt_d;
    logic [63:0]   hash_q, hash_d;
    logic          in_ready_q, in_ready_d;
    logic          load_q, load_d;
    logic          round_en_q, round_en_d;
    logic          shift2_q, shift2_d;
    logic          iter_end_q, iter_end_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic          abort_i;
    logic [63:0]   fp_lr;

`ifdef DESCRYPT_CTRL_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    for (genvar g = 0; g < 64; g++) begin : g_fp
        assign fp_lr[63-g] = dp_lr[FP_SRC[g]];
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        iter_d  = iter_q;
        key_d   = key_q;
        salt_d  = salt_q;
        hash_d  = hash_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && !abort_i) begin
                    key_d   = in_key;
                    salt_d  = in_salt;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                round_d = '0;
                iter_d  = '0;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (round_q == ROUND_LAST) begin
                    state_d = S_ITER_END;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_ITER_END: begin
                round_d = '0;
                if (iter_q == ITER_LAST) begin
                    hash_d  = fp_lr;
                    state_d = S_DONE;
                end else begin
                    iter_d  = iter_q + IW'(1);
                    state_d = S_ROUND;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort drops the job without touching the previously captured result.
        if (abort_i && (state_q inside {S_LOAD, S_ROUND, S_ITER_END})) begin
            state_d = S_IDLE;
            round_d = '0;
            iter_d  = '0;
            hash_d  = hash_q;
        end

        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        load_d      = (state_d == S_LOAD);
        round_en_d  = (state_d == S_ROUND);
        shift2_d    = (state_d == S_ROUND) && !(round_d inside {4'd0, 4'd1, 4'd8, 4'd15});
        iter_end_d  = (state_d == S_ITER_END);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            round_q     <= '0;
            iter_q      <= '0;
            key_q       <= '0;
            salt_q      <= '0;
            hash_q      <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            load_q      <= 1'b0;
            round_en_q  <= 1'b0;
            shift2_q    <= 1'b0;
            iter_end_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            iter_q      <= iter_d;
            key_q       <= key_d;
            salt_q      <= salt_d;
            hash_q      <= hash_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            load_q      <= load_d;
            round_en_q  <= round_en_d;
            shift2_q    <= shift2_d;
            iter_end_q  <= iter_end_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign dp_load     = load_q;
    assign dp_key      = key_q;
    assign dp_salt     = salt_q;
    assign dp_round_en = round_en_q;
    assign dp_shift2   = shift2_q;
    assign dp_iter_end = iter_end_q;
    assign out_valid   = out_valid_q;
    assign out_hash    = hash_q;

endmodule

// File: tb/tb_descrypt_round_ctrl.sv
// Bench for descrypt_round_ctrl: FP vector table, handshake corner cases and random jobs vs a timeline model.
module tb_descrypt_round_ctrl;
    localparam int ITERATIONS = 25;
    localparam int ROUNDS     = 16;
    localparam int SPAN       = ROUNDS + 1;
    localparam int LAST_T     = ITERATIONS * SPAN;
    localparam int LATENCY    = 1 + ITERATIONS * SPAN;

    logic        CLK, rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [55:0] in_key, dp_key;
    logic [11:0] in_salt, dp_salt;
    logic        dp_load, dp_round_en, dp_shift2, dp_iter_end;
    logic [63:0] dp_lr, out_hash;
    logic        abort_drv;

    descrypt_round_ctrl #(.ITERATIONS(ITERATIONS), .ROUNDS(ROUNDS)) dut (
        .CLK(CLK), .rst_n(rst_n),
`ifdef DESCRYPT_CTRL_ABORT_EN
        .abort(abort_drv),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_salt(in_salt),
        .dp_load(dp_load), .dp_key(dp_key), .dp_salt(dp_salt),
        .dp_round_en(dp_round_en), .dp_shift2(dp_shift2), .dp_iter_end(dp_iter_end),
        .dp_lr(dp_lr), .out_valid(out_valid), .out_ready(out_ready),
        .out_hash(out_hash), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    int shift_pat [16] = '{0,0,1,1,1,1,1,1,0,1,1,1,1,1,1,0};
    int ip_tab [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                        62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                        57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
                        61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};

    // Model: 0 idle, 1 running (m_t = edges since accept), 2 result waiting.
    int          m_mode, m_t;
    logic [55:0] m_key;
    logic [11:0] m_salt;
    logic [63:0] m_hash;
    logic        lr_forced;
    logic [63:0] lr_final;
    int          ren_cnt, ie_cnt, s2_cnt;

    // FP is the inverse of IP: wherever IP sends a bit, FP brings it back.
    function automatic logic [63:0] ref_fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 1; i <= 64; i++) y[64 - ip_tab[i-1]] = x[64 - i];
        return y;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_key = '0; m_salt = '0; m_hash = '0;
        s2_cnt = 0;
    endtask

    task automatic model_edge();
        case (m_mode)
            0: if (in_valid && !abort_drv) begin
                   m_mode = 1; m_t = 0; m_key = in_key; m_salt = in_salt;
               end
            1: if (abort_drv) m_mode = 0;
               else if (m_t == LAST_T) begin m_mode = 2; m_hash = ref_fp(dp_lr); end
               else m_t++;
            default: if (out_ready) m_mode = 0;
        endcase
    endtask

    task automatic check_all();
        logic [6:0] exp_f, act_f;
        logic e_load, e_ren, e_s2, e_ie;
        int rnd;
        e_load = 0; e_ren = 0; e_s2 = 0; e_ie = 0;
        if (m_mode == 1) begin
            if (m_t == 0) e_load = 1;
            else begin
                rnd = (m_t - 1) % SPAN;
                if (rnd < ROUNDS) begin
                    e_ren = 1;
                    e_s2 = (shift_pat[rnd] != 0);
                end else e_ie = 1;
            end
        end
        exp_f = {m_mode == 0, m_mode != 0, m_mode == 2, e_load, e_ren, e_s2, e_ie};
        act_f = {in_ready, busy, out_valid, dp_load, dp_round_en, dp_shift2, dp_iter_end};
        check("flags{rdy,busy,ov,ld,ren,s2,ie}", 64'(act_f), 64'(exp_f));
        check("dp_key", 64'(dp_key), 64'(m_key));
        check("dp_salt", 64'(dp_salt), 64'(m_salt));
        check("out_hash", out_hash, m_hash);
    endtask

    task automatic cycle();
        if (lr_forced && m_mode == 1 && m_t == LAST_T) dp_lr = lr_final;
        else dp_lr = {$urandom, $urandom};
        model_edge();
        @(posedge CLK);
        #1;
        check_all();
        if (dp_load) s2_cnt = 0;
        if (dp_round_en) ren_cnt++;
        if (dp_shift2) s2_cnt++;
        if (dp_iter_end) begin
            ie_cnt++;
            check("shift2_per_iter", 64'(s2_cnt), 64'd12);
            s2_cnt = 0;
        end
    endtask

    task automatic run_job(input logic [55:0] k, input logic [11:0] s, output int lat);
        in_key = k; in_salt = s; in_valid = 1'b1; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 600) begin cycle(); lat++; end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!out_valid && n < 600) begin cycle(); n++; end
        check("drain_done", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    typedef struct { logic [63:0] lr; logic [63:0] hash; } fp_vec_t;
    fp_vec_t tab [6];

    initial begin
        int lat;
        logic [55:0] k2;
        tab[0] = '{64'h8000000000000000, 64'h0000000000000040};
        tab[1] = '{64'h0000000000000001, 64'h0200000000000000};
        tab[2] = '{64'h0000000001000000, 64'h8000000000000000};
        tab[3] = '{64'h0100000000000000, 64'h4000000000000000};
        tab[4] = '{64'h0000000000000000, 64'h0000000000000000};
        tab[5] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; abort_drv = 1'b0;
        in_key = '0; in_salt = '0; dp_lr = '0; lr_forced = 1'b0; lr_final = '0;
        ren_cnt = 0; ie_cnt = 0;
        model_reset();
        #12;
        check_all();
        #2 rst_n = 1'b1;
        cycle();

        // FP capture and single-job timing, one job per table row
        lr_forced = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lr_final = tab[i].lr;
            ren_cnt = 0; ie_cnt = 0;
            run_job({$urandom, $urandom}, 12'($urandom), lat);
            check("latency", 64'(lat), 64'(LATENCY));
            check("fp_table_hash", out_hash, tab[i].hash);
            check("round_en_pulses", 64'(ren_cnt), 64'(ROUNDS * ITERATIONS));
            check("iter_end_pulses", 64'(ie_cnt), 64'(ITERATIONS));
            out_ready = 1'b1;
            cycle();
            out_ready = 1'b0;
        end
        lr_forced = 1'b0;

        // Back-pressure with a second job waiting upstream
        run_job(56'h0123456789ABCD, 12'hA5C, lat);
        k2 = 56'hFEDCBA98765432;
        in_key = k2; in_salt = 12'h3C3; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cycle();
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        check("bp_valid_dropped", 64'(out_valid), 64'd0);
        cycle();
        check("bp_second_load", 64'(dp_load), 64'd1);
        check("bp_second_key", 64'(dp_key), 64'(k2));
        in_valid = 1'b0;
        drain();

        // Asynchronous reset at iteration 3, round 7
        in_key = 56'h00AABBCCDDEEFF; in_salt = 12'h123; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 1 + 3 * SPAN + 7; i++) cycle();
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("rst_busy_low", 64'(busy), 64'd0);
        #2 rst_n = 1'b1;
        cycle();
        check("rst_release_ready", 64'(in_ready), 64'd1);

`ifdef DESCRYPT_CTRL_ABORT_EN
        // Abort blocks acceptance in IDLE, then kills a job at iteration 10
        in_valid = 1'b1; abort_drv = 1'b1;
        cycle();
        check("abort_idle_block", 64'(dp_load), 64'd0);
        abort_drv = 1'b0;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 1 + 10 * SPAN; i++) cycle();
        abort_drv = 1'b1;
        cycle();
        abort_drv = 1'b0;
        check("abort_to_idle", 64'(in_ready), 64'd1);
        for (int i = 0; i < 500; i++) begin
            cycle();
            if (out_valid) check("abort_no_result", 64'(out_valid), 64'd0);
        end
        run_job(56'h13579BDF02468A, 12'h0F0, lat);
        check("abort_next_latency", 64'(lat), 64'(LATENCY));
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
`endif

        // Random traffic against the timeline model
        for (int i = 0; i < 9000; i++) begin
            in_valid  = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 7) == 0);
            in_key    = {$urandom, $urandom};
            in_salt   = 12'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 600; i++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
